fpu_issue_ctrl: RTL and testbench
=================================

# fpu_issue_ctrl

Issue controller that shares one fixed-latency FPU pipeline (unpack stage onward) between `NUM_REQ` requesters. Accepts operand/operator requests through valid/ready handshakes and arbitrates round-robin. Drives the FPU input bus, tracks in-flight operations with a tag shift register, and returns each result to its originating requester through a held response register. Sits between the requester ports (core/DMA-side) and the `fpu_unpack` input of the FPU datapath.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `PIPE_LATENCY`, 4: cycles from an `fpu_valid` cycle to the cycle `fpu_result` is valid (≥1); identical for all operators.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in NUM_REQ: request present, one bit per requester.
- `req_ready` out NUM_REQ: request accepted this cycle (one-hot or zero).
- `req_operand_a` in 32*NUM_REQ: packed IEEE-754 single operand A, requester i at [32i+31:32i].
- `req_operand_b` in 32*NUM_REQ: packed operand B.
- `req_operator` in 2*NUM_REQ: packed operator code, passed through unmodified.
- `fpu_valid` out 1: issue strobe to FPU.
- `fpu_operand_a` out 32: to FPU `in_operand_a`.
- `fpu_operand_b` out 32: to FPU `in_operand_b`.
- `fpu_operator` out 2: to FPU `in_operator`.
- `fpu_result` in 32: FPU result, valid `PIPE_LATENCY` cycles after issue.
- `resp_valid` out NUM_REQ: result held for requester i.
- `resp_ready` in NUM_REQ: requester i consumes result.
- `resp_result` out 32*NUM_REQ: packed held results.
- `busy` out NUM_REQ: requester i has an operation in flight or an unconsumed result.

## Operation
- Eligibility: `elig[i] = req_valid[i] & ~busy[i]`. Each requester has at most one outstanding operation, so a response slot can never overflow.
- Arbiter: pointer `ptr` (reset 0). Grant goes to the first eligible index scanning `ptr, ptr+1, …` mod NUM_REQ. `req_ready` is combinational: the one-hot grant. No grant means all zero.
- On grant g at a clock edge:
  - `ptr <= (g+1) mod NUM_REQ`.
  - `busy[g] <= 1`.
  - `fpu_valid <= 1`; operands and operator of g are registered onto the `fpu_*` outputs.
  - Tag `{1, g}` is pushed into the tag pipe.
- Without a grant: `fpu_valid <= 0`, `fpu_operand_*`/`fpu_operator` hold their last values, and an invalid tag is pushed. `ptr` is unchanged.
- Tag pipe: `PIPE_LATENCY`-deep shift register of {valid, id}, aligned with `fpu_valid`. When the tag exiting in cycle k+PIPE_LATENCY is valid, `fpu_result` is captured into slot[id] at the end of that cycle and `resp_valid[id] <= 1`.
- Response: `resp_result` slot i and `resp_valid[i]` hold stable until `resp_valid[i] & resp_ready[i]`. At that edge `resp_valid[i] <= 0` and `busy[i] <= 0`.
- `resp_ready` while `resp_valid` is low is ignored.
- Simultaneous events:
  - Capture for i and handshake for i in the same cycle cannot occur (busy invariant).
  - Captures for different requesters and grants proceed independently in the same cycle.
- A requester whose busy clears at edge e is eligible from cycle e onward (no same-cycle reissue on the handshake cycle).

## Timing
- Reset (async assert, sync-released by the system):
  - `req_ready`, `fpu_valid`, `resp_valid`, `busy` = 0.
  - `fpu_operand_a/b`, `fpu_operator`, `resp_result` = 0.
  - `ptr` = 0; all tags invalid.
- Reset mid-operation: in-flight tags are discarded, and FPU results emerging after reset are ignored (invalid tags).
- Latency, grant in cycle g:
  - `fpu_valid` in g+1.
  - `fpu_result` in g+1+PIPE_LATENCY.
  - `resp_valid` from g+2+PIPE_LATENCY (g+6 at default).
- Throughput: one issue per cycle across requesters; per requester, one operation per (PIPE_LATENCY+3) cycles minimum with immediate `resp_ready`.

## Test plan
- Reset: hold `rst_n`=0 with random inputs -> all outputs 0. Release -> first grant to requester 0 when all are valid.
- Single op: req 0, a=0x3FA00000, b=0x3FC00000, op=00, granted in cycle g -> `fpu_valid`=1 in g+1 with those values. Model returns 0x40300000 at g+5 -> `resp_valid[0]`=1 and `resp_result[0]`=0x40300000 from g+6. Held until `resp_ready[0]`, then `busy[0]`=0.
- Contention: all four valid from reset -> grants 0,1,2,3 on consecutive cycles. `req_ready` stays 0 thereafter until each handshake. Responses arrive in order 0,1,2,3 on consecutive cycles.
- Round-robin: after grant to 2, requesters 1 and 3 valid -> 3 granted first, then 1.
- Backpressure: `resp_ready[1]`=0 for 10 cycles -> `resp_result[1]` stable and `busy[1]`=1. Requester 1 is never granted despite `req_valid[1]`; requesters 0/2 are still granted and answered.
- Reset in flight: `rst_n` low 2 cycles after issue -> after release no `resp_valid` ever appears for that op, and the late `fpu_result` is ignored.

Source files
------------

// File: rtl/fpu_issue_ctrl.sv
// Round-robin issue controller sharing one fixed-latency FPU pipeline between NUM_REQ requesters.
// Results are routed back by a tag shift register aligned with the FPU issue strobe.
module fpu_issue_ctrl #(
   parameter int NUM_REQ      = 4,
   parameter int PIPE_LATENCY = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [32*NUM_REQ-1:0]    req_operand_a,
   input  logic [32*NUM_REQ-1:0]    req_operand_b,
   input  logic [2*NUM_REQ-1:0]     req_operator,
   output logic                     fpu_valid,
   output logic [31:0]              fpu_operand_a,
   output logic [31:0]              fpu_operand_b,
   output logic [1:0]               fpu_operator,
   input  logic [31:0]              fpu_result,
   output logic [NUM_REQ-1:0]       resp_valid,
   input  logic [NUM_REQ-1:0]       resp_ready,
   output logic [32*NUM_REQ-1:0]    resp_result,
   output logic [NUM_REQ-1:0]       busy
);

   localparam int IDW = $clog2(NUM_REQ);

   logic [IDW-1:0]     ptr_q, ptr_d;
   logic [NUM_REQ-1:0] busy_q, busy_d;
   logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
   logic               fpu_valid_q;
   logic [31:0]        fpu_a_q, fpu_b_q;
   logic [1:0]         fpu_op_q;
   logic [PIPE_LATENCY:0] tag_valid_q;
   logic [IDW-1:0]     tag_id_q [PIPE_LATENCY+1];
   logic [31:0]        slot_q [NUM_REQ];

   logic [31:0]        op_a [NUM_REQ];
   logic [31:0]        op_b [NUM_REQ];
   logic [1:0]         op_c [NUM_REQ];
   logic [NUM_REQ-1:0] elig, grant_vec, hs, cap_sel;
   logic               grant_any;
   logic [IDW-1:0]     grant_id;
   logic               cap_valid;
   logic [IDW-1:0]     cap_id;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_port
         assign op_a[gi] = req_operand_a[32*gi +: 32];
         assign op_b[gi] = req_operand_b[32*gi +: 32];
         assign op_c[gi] = req_operator[2*gi +: 2];
         assign resp_result[32*gi +: 32] = slot_q[gi];
         assign cap_sel[gi] = cap_valid && (cap_id == IDW'(gi));
      end
   endgenerate

   // Gating with rst_n keeps req_ready low while reset is held.
   assign elig = req_valid & ~busy_q & {NUM_REQ{rst_n}};

   always_comb begin
      logic [IDW:0] idx;
      idx       = '0;
      grant_any = 1'b0;
      grant_id  = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         idx = {1'b0, ptr_q} + (IDW+1)'(off);
         if (idx >= (IDW+1)'(NUM_REQ)) begin
            idx = idx - (IDW+1)'(NUM_REQ);
         end
         if (!grant_any && elig[idx[IDW-1:0]]) begin
            grant_any = 1'b1;
            grant_id  = idx[IDW-1:0];
         end
      end
   end

   always_comb begin
      grant_vec = '0;
      ptr_d     = ptr_q;
      if (grant_any) begin
         grant_vec = NUM_REQ'(1) << grant_id;
         ptr_d     = (grant_id == IDW'(NUM_REQ-1)) ? '0 : grant_id + IDW'(1);
      end
   end

   assign cap_valid    = tag_valid_q[PIPE_LATENCY];
   assign cap_id       = tag_id_q[PIPE_LATENCY];
   assign hs           = resp_valid_q & resp_ready;
   assign resp_valid_d = (resp_valid_q & ~hs) | cap_sel;
   assign busy_d       = (busy_q & ~hs) | grant_vec;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q        <= '0;
         busy_q       <= '0;
         resp_valid_q <= '0;
         fpu_valid_q  <= 1'b0;
         fpu_a_q      <= '0;
         fpu_b_q      <= '0;
         fpu_op_q     <= '0;
         tag_valid_q  <= '0;
         for (int s = 0; s <= PIPE_LATENCY; s++) begin
            tag_id_q[s] <= '0;
         end
      end else begin
         ptr_q        <= ptr_d;
         busy_q       <= busy_d;
         resp_valid_q <= resp_valid_d;
         fpu_valid_q  <= grant_any;
         if (grant_any) begin
            fpu_a_q  <= op_a[grant_id];
            fpu_b_q  <= op_b[grant_id];
            fpu_op_q <= op_c[grant_id];
         end
         // Stage 0 is aligned with fpu_valid; the last stage lines up with fpu_result.
         tag_valid_q <= {tag_valid_q[PIPE_LATENCY-1:0], grant_any};
         tag_id_q[0] <= grant_id;
         for (int s = 1; s <= PIPE_LATENCY; s++) begin
            tag_id_q[s] <= tag_id_q[s-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (cap_sel[i]) begin
               slot_q[i] <= fpu_result;
            end
         end
      end
   end

   assign req_ready     = grant_vec;
   assign fpu_valid     = fpu_valid_q;
   assign fpu_operand_a = fpu_a_q;
   assign fpu_operand_b = fpu_b_q;
   assign fpu_operator  = fpu_op_q;
   assign resp_valid    = resp_valid_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl: a transaction-level model predicts grants and response timing,
// while separate monitors check the FPU bus and returned results.
module tb_fpu_issue_ctrl;
   localparam int N = 4;
   localparam int L = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_ready;
   logic [32*N-1:0] req_operand_a = '0;
   logic [32*N-1:0] req_operand_b = '0;
   logic [2*N-1:0] req_operator = '0;
   logic           fpu_valid;
   logic [31:0]    fpu_operand_a, fpu_operand_b;
   logic [1:0]     fpu_operator;
   logic [31:0]    fpu_result;
   logic [N-1:0]   resp_valid;
   logic [N-1:0]   resp_ready = '0;
   logic [32*N-1:0] resp_result;
   logic [N-1:0]   busy;

   fpu_issue_ctrl #(.NUM_REQ(N), .PIPE_LATENCY(L)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_operand_a(req_operand_a), .req_operand_b(req_operand_b), .req_operator(req_operator),
      .fpu_valid(fpu_valid), .fpu_operand_a(fpu_operand_a), .fpu_operand_b(fpu_operand_b),
      .fpu_operator(fpu_operator), .fpu_result(fpu_result),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
      if (a == 32'h3FA00000 && b == 32'h3FC00000 && op == 2'b00) return 32'h40300000;
      return (a ^ {b[15:0], b[31:16]}) + {30'b0, op};
   endfunction

   // Stand-in FPU: fixed latency, garbage on idle cycles, not reset.
   logic [31:0] res_pipe [L];
   always @(posedge clk) begin
      res_pipe[0] <= fpu_valid ? fpu_fn(fpu_operand_a, fpu_operand_b, fpu_operator) : $urandom;
      for (int s = 1; s < L; s++) res_pipe[s] <= res_pipe[s-1];
   end
   assign fpu_result = res_pipe[L-1];

   typedef struct { logic [31:0] a; logic [31:0] b; logic [1:0] op; } fpu_t;
   typedef struct { int id; logic [31:0] res; } rsp_t;
   fpu_t fpu_q[$];
   rsp_t rsp_q[$];

   function automatic int find_rsp(input int id);
      foreach (rsp_q[k]) if (rsp_q[k].id == id) return k;
      return -1;
   endfunction

   // Reference model: one outstanding op per requester, response visible from grant+2+L.
   int           ptr_m = 0;
   logic [N-1:0] busy_m = '0;
   int           avail_m [N];
   logic         granted_last = 1'b0;

   always @(negedge clk) begin : model
      int g;
      int idx;
      logic [N-1:0] exp_rdy, exp_rv;
      if (!rst_n) begin
         chk("rst_req_ready", 32'(req_ready), 32'h0);
         chk("rst_fpu_valid", 32'(fpu_valid), 32'h0);
         chk("rst_resp_valid", 32'(resp_valid), 32'h0);
         chk("rst_busy", 32'(busy), 32'h0);
         chk("rst_fpu_a", fpu_operand_a, 32'h0);
         chk("rst_fpu_b", fpu_operand_b, 32'h0);
         chk("rst_fpu_op", 32'(fpu_operator), 32'h0);
         for (int i = 0; i < N; i++) chk("rst_resp_result", resp_result[32*i +: 32], 32'h0);
         ptr_m = 0;
         busy_m = '0;
         granted_last = 1'b0;
         fpu_q.delete();
         rsp_q.delete();
      end else begin
         g = -1;
         for (int off = 0; off < N; off++) begin
            idx = (ptr_m + off) % N;
            if (g < 0 && req_valid[idx] && !busy_m[idx]) g = idx;
         end
         exp_rdy = '0;
         if (g >= 0) exp_rdy[g] = 1'b1;
         for (int i = 0; i < N; i++) exp_rv[i] = busy_m[i] && (cyc >= avail_m[i]);
         chk("req_ready", 32'(req_ready), 32'(exp_rdy));
         chk("fpu_valid", 32'(fpu_valid), 32'(granted_last));
         chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
         chk("busy", 32'(busy), 32'(busy_m));
         for (int i = 0; i < N; i++) if (exp_rv[i] && resp_ready[i]) busy_m[i] = 1'b0;
         granted_last = (g >= 0);
         if (g >= 0) begin
            fpu_t f;
            rsp_t r;
            f.a  = req_operand_a[32*g +: 32];
            f.b  = req_operand_b[32*g +: 32];
            f.op = req_operator[2*g +: 2];
            r.id  = g;
            r.res = fpu_fn(f.a, f.b, f.op);
            fpu_q.push_back(f);
            rsp_q.push_back(r);
            busy_m[g]  = 1'b1;
            avail_m[g] = cyc + 2 + L;
            ptr_m      = (g + 1) % N;
         end
      end
   end

   always @(negedge clk) begin : fpu_mon
      fpu_t e;
      if (rst_n && fpu_valid) begin
         if (fpu_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL fpu_issue: fpu_valid=1 with nothing expected (cycle %0d)", cyc);
         end else begin
            e = fpu_q.pop_front();
            chk("fpu_operand_a", fpu_operand_a, e.a);
            chk("fpu_operand_b", fpu_operand_b, e.b);
            chk("fpu_operator", 32'(fpu_operator), 32'(e.op));
         end
      end
   end

   always @(negedge clk) begin : resp_mon
      int k;
      if (rst_n) begin
         for (int i = 0; i < N; i++) begin
            if (resp_valid[i]) begin
               k = find_rsp(i);
               if (k < 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL resp_unexpected: resp_valid[%0d]=1 with nothing expected (cycle %0d)", i, cyc);
               end else begin
                  chk("resp_result", resp_result[32*i +: 32], rsp_q[k].res);
                  if (resp_ready[i]) begin
                     $display("resp req%0d result %h cycle %0d", i, resp_result[32*i +: 32], cyc);
                     rsp_q.delete(k);
                  end
               end
            end
         end
      end
   end

   task automatic rand_ops();
      for (int i = 0; i < N; i++) begin
         req_operand_a[32*i +: 32] = $urandom;
         req_operand_b[32*i +: 32] = $urandom;
         req_operator[2*i +: 2]    = 2'($urandom_range(0, 3));
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         req_valid  = '0;
         resp_ready = '1;
         rand_ops();
      end
   endtask

   initial begin
      rand_ops();
      req_valid  = N'($urandom);
      resp_ready = N'($urandom);
      #1 rst_n = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         req_valid  = N'($urandom);
         resp_ready = N'($urandom);
         rand_ops();
      end
      // Contention: everyone valid straight out of reset.
      @(posedge clk); #1;
      rst_n      = 1'b1;
      req_valid  = '1;
      resp_ready = '1;
      repeat (12) begin
         @(posedge clk); #1;
         rand_ops();
      end
      idle(12);

      // Directed single op on requester 0, held response.
      @(posedge clk); #1;
      req_valid  = 4'b0001;
      resp_ready = '0;
      req_operand_a[31:0] = 32'h3FA00000;
      req_operand_b[31:0] = 32'h3FC00000;
      req_operator[1:0]   = 2'b00;
      @(posedge clk); #1;
      req_valid = '0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      chk("single_resp_valid0", 32'(resp_valid[0]), 32'h1);
      chk("single_resp_result0", resp_result[31:0], 32'h40300000);
      chk("single_busy0", 32'(busy[0]), 32'h1);
      @(posedge clk); #1;
      resp_ready = '1;
      idle(3);

      // Random traffic with a requester-1 backpressure window and a global stall.
      for (int t = 0; t < 300; t++) begin
         @(posedge clk); #1;
         rand_ops();
         req_valid  = N'($urandom);
         resp_ready = N'($urandom) | N'($urandom);
         if (t >= 50 && t < 62) begin
            resp_ready[1] = 1'b0;
            req_valid[1]  = 1'b1;
         end
         if (t >= 150 && t < 165) resp_ready = '0;
      end
      idle(15);

      // Reset while an op is in flight: its late result must be dropped.
      @(posedge clk); #1;
      req_valid = 4'b0100;
      @(posedge clk); #1;
      req_valid = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(15);

      @(negedge clk);
      chk("pending_responses", 32'(rsp_q.size()), 32'h0);
      chk("pending_issues", 32'(fpu_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
